// File: rtl/hash_pkg.sv
// Shared definitions for the Hash block: header geometry and the feeder state enum.
package hash_pkg;

  localparam int HDR_W     = 640;
  localparam int WORD_W    = 32;
  localparam int HDR_WORDS = 20;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } feed_state_t;

endpackage

// File: rtl/nonce_counter.sv
// Nonce sweep helper: holds the programmed last nonce, supplies the incremented
// nonce and flags when the current nonce is the last one of the sweep.
module nonce_counter (
  input  logic        clk,
  input  logic        last_load,
  input  logic [31:0] last_in,
  input  logic [31:0] cur_nonce,
  output logic [31:0] next_nonce,
  output logic        is_last
);

  logic [31:0] last_q;
  logic [31:0] last_d;

  always_comb begin
    last_d = last_q;
    if (last_load) begin
      last_d = last_in;
    end
  end

  // Data register only; it is always rewritten before the sweep that uses it.
  always_ff @(posedge clk) begin
    last_q <= last_d;
  end

  assign next_nonce = cur_nonce + 32'd1;
  assign is_last    = (cur_nonce == last_q);

endmodule

// File: rtl/header_feeder.sv
// Assembles a 640-bit block header from 32-bit words and emits it (optionally
// sweeping the nonce when NONCE_SWEEP_EN is defined) over a valid/ready link.
module header_feeder
  import hash_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int HDR_WORDS = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_W-1:0]           in_word,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 nonce_last,
  input  logic                        abort,
  output logic [HDR_WORDS*WORD_W-1:0] hdr,
  output logic                        hdr_valid,
  input  logic                        hdr_ready,
  output logic                        busy,
  output logic                        done
);

  feed_state_t                 state_q, state_d;
  logic [4:0]                  widx_q, widx_d;
  logic [HDR_WORDS*WORD_W-1:0] hdr_q, hdr_d;
  logic                        in_ready_q, in_ready_d;
  logic                        hdr_valid_q, hdr_valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic word_acc;
  logic last_word;
  logic is_last;

  assign word_acc  = (state_q == LOAD) && in_valid && in_ready_q && !abort;
  assign last_word = word_acc && (widx_q == 5'(HDR_WORDS - 1));

`ifdef NONCE_SWEEP_EN
  logic [31:0] next_nonce;

  nonce_counter u_nonce_counter (
    .clk        (clk),
    .last_load  (last_word),
    .last_in    (nonce_last),
    .cur_nonce  (hdr_q[31:0]),
    .next_nonce (next_nonce),
    .is_last    (is_last)
  );
`else
  logic unused_nonce_last;

  assign unused_nonce_last = ^nonce_last;
  // Without the sweep every header is the last one.
  assign is_last = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    hdr_d   = hdr_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = LOAD;
      widx_d  = 5'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (word_acc) begin
            // Word 0 lands in the most significant slot.
            for (int i = 0; i < HDR_WORDS; i++) begin
              if (widx_q == i[4:0]) begin
                hdr_d[(HDR_WORDS-1-i)*WORD_W +: WORD_W] = in_word;
              end
            end
            if (last_word) begin
              widx_d  = 5'd0;
              state_d = EMIT;
            end else begin
              widx_d = widx_q + 5'd1;
            end
          end
        end
        EMIT: begin
          if (hdr_valid_q && hdr_ready) begin
            if (is_last) begin
              done_d  = 1'b1;
              state_d = LOAD;
            end else begin
`ifdef NONCE_SWEEP_EN
              hdr_d[31:0] = next_nonce;
`endif
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end

    in_ready_d  = (state_d == LOAD);
    hdr_valid_d = (state_d == EMIT);
    busy_d      = (state_d == EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      widx_q      <= 5'd0;
      hdr_q       <= '0;
      in_ready_q  <= 1'b0;
      hdr_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      hdr_q       <= hdr_d;
      in_ready_q  <= in_ready_d;
      hdr_valid_q <= hdr_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign hdr       = hdr_q;
  assign hdr_valid = hdr_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_header_feeder.sv
// Directed bench for header_feeder; expectations follow NONCE_SWEEP_EN.
module tb_header_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  nonce_last;
  logic         abort;
  logic [639:0] hdr;
  logic         hdr_valid;
  logic         hdr_ready;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_words [20];

  typedef struct {
    int          grp;
    logic        rdy;
    logic        abrt;
    logic        inv;
    logic        e_valid;
    logic        e_done;
    logic        e_inrdy;
    logic [31:0] e_nonce;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  header_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .nonce_last (nonce_last),
    .abort      (abort),
    .hdr        (hdr),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [639:0] model(input logic [31:0] n);
    logic [639:0] r;
    for (int i = 0; i < 19; i++) r[(19-i)*32 +: 32] = exp_words[i];
    r[31:0] = n;
    return r;
  endfunction

  task automatic addv(input int g, input logic r, input logic a, input logic iv,
                      input logic ev, input logic ed, input logic eir, input logic [31:0] n);
    vec_t v;
    v.grp = g; v.rdy = r; v.abrt = a; v.inv = iv;
    v.e_valid = ev; v.e_done = ed; v.e_inrdy = eir; v.e_nonce = n;
    vecs.push_back(v);
  endtask

  task automatic wait_in_ready();
    int k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("in_ready_wait", {639'd0, in_ready}, 640'd1);
  endtask

  // Full 20-word load: words base+i for slots 0..18, nonce in slot 19.
  task automatic load(input logic [31:0] base, input logic [31:0] nonce, input logic [31:0] last);
    wait_in_ready();
    hdr_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_words[i] = (i == 19) ? nonce : base + 32'(i);
      in_word  = exp_words[i];
      in_valid = 1'b1;
      nonce_last = (i == 19) ? last : 32'hCAFE0000;
      step();
      if (i < 19) begin
        chk("load_no_valid", {639'd0, hdr_valid}, 640'd0);
      end
    end
    in_valid = 1'b0;
    chk("load_valid", {639'd0, hdr_valid}, 640'd1);
    chk("load_busy", {639'd0, busy}, 640'd1);
    chk("load_in_ready_low", {639'd0, in_ready}, 640'd0);
    chk("load_hdr", hdr, model(nonce));
    chk("load_word0", {608'd0, hdr[639:608]}, {608'd0, base});
  endtask

  task automatic run_group(input int g);
    foreach (vecs[k]) begin
      if (vecs[k].grp == g) begin
        hdr_ready = vecs[k].rdy;
        abort     = vecs[k].abrt;
        in_valid  = vecs[k].inv;
        in_word   = 32'hDEAD0000;
        step();
        chk($sformatf("g%0d_v%0d_valid", g, k), {639'd0, hdr_valid}, {639'd0, vecs[k].e_valid});
        chk($sformatf("g%0d_v%0d_busy", g, k), {639'd0, busy}, {639'd0, vecs[k].e_valid});
        chk($sformatf("g%0d_v%0d_done", g, k), {639'd0, done}, {639'd0, vecs[k].e_done});
        chk($sformatf("g%0d_v%0d_in_ready", g, k), {639'd0, in_ready}, {639'd0, vecs[k].e_inrdy});
        if (vecs[k].e_valid) begin
          chk($sformatf("g%0d_v%0d_hdr", g, k), hdr, model(vecs[k].e_nonce));
        end
      end
    end
    hdr_ready = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_word = '0; in_valid = 1'b0; nonce_last = '0;
    abort = 1'b0; hdr_ready = 1'b0;

    // Five stall cycles with a stray in_valid, then release.
    for (int i = 0; i < 5; i++) addv(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef NONCE_SWEEP_EN
    addv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
    addv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2);
    addv(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    addv(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    addv(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000);
    addv(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000001);
    addv(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    addv(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h6);
`else
    addv(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    addv(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
`endif
    addv(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    addv(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    step();
    step();
    chk("rst_in_ready", {639'd0, in_ready}, 640'd0);
    chk("rst_hdr_valid", {639'd0, hdr_valid}, 640'd0);
    chk("rst_busy", {639'd0, busy}, 640'd0);
    chk("rst_done", {639'd0, done}, 640'd0);
    chk("rst_hdr", hdr, 640'd0);
    rst = 1'b0;

    load(32'h00000001, 32'h00000000, 32'h00000002);
    run_group(0);
    // Next load starts in the done cycle itself.
`ifdef NONCE_SWEEP_EN
    load(32'h00000100, 32'hFFFFFFFE, 32'h00000001);
`else
    load(32'h00000100, 32'h12345678, 32'h00000000);
`endif
    run_group(1);

    // Abort after seven words, with a word offered in the abort cycle.
    wait_in_ready();
    for (int i = 0; i < 7; i++) begin
      in_word = 32'h50 + 32'(i); in_valid = 1'b1;
      step();
    end
    in_word = 32'hBAD0BAD0; abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_load_valid", {639'd0, hdr_valid}, 640'd0);
    chk("abort_load_done", {639'd0, done}, 640'd0);
    chk("abort_load_in_ready", {639'd0, in_ready}, 640'd1);

`ifdef NONCE_SWEEP_EN
    load(32'h00000200, 32'h00000005, 32'h00000009);
`else
    load(32'h00000200, 32'h12345678, 32'h00000000);
`endif
    run_group(2);

    // Reset during EMIT together with a handshake.
    load(32'h00000300, 32'h00000007, 32'h00000009);
    hdr_ready = 1'b1;
    rst = 1'b1;
    step();
    chk("rst_emit_valid", {639'd0, hdr_valid}, 640'd0);
    chk("rst_emit_busy", {639'd0, busy}, 640'd0);
    chk("rst_emit_done", {639'd0, done}, 640'd0);
    chk("rst_emit_in_ready", {639'd0, in_ready}, 640'd0);
    chk("rst_emit_hdr", hdr, 640'd0);
    rst = 1'b0;
    hdr_ready = 1'b0;
    step();
    chk("post_rst_done", {639'd0, done}, 640'd0);
    chk("post_rst_valid", {639'd0, hdr_valid}, 640'd0);
    chk("post_rst_in_ready", {639'd0, in_ready}, 640'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
